// File: rtl/dcache_traffic_gen_if.sv
// CPU-side request bus of the data-cache traffic generator, with its configuration and control.
// The master modport is the generator; the slave modport is whoever drives it (bench, SoC harness).
interface dcache_traffic_gen_if #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 64
);
  localparam int IW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          cfg_wr;
  logic          start;
  logic [1:0]    mode;
  logic [NW-1:0] num_ops;
  logic          stall;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] address;
  logic [DW-1:0] writedata;
  logic          busy;
  logic          done;
  logic [NW-1:0] ops_issued;

  modport master (
    input  cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_wr,
    input  start, mode, num_ops, stall,
    output mem_read, mem_write, address, writedata,
    output busy, done, ops_issued
  );

  modport slave (
    output cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_wr,
    output start, mode, num_ops, stall,
    input  mem_read, mem_write, address, writedata,
    input  busy, done, ops_issued
  );
endinterface

// File: rtl/dcache_traffic_gen.sv
// Memory-request stimulus generator for the data-cache CPU port: script table or built-in
// address/data patterns, throttled by stall, with registered strobes and progress reporting.
module dcache_traffic_gen #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0,
  parameter int STRIDE    = 4,
  parameter int DATA_SEED = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  dcache_traffic_gen_if.master bus,
  output logic [1:0]           state_dbg
);
  localparam int IW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] BASE_A  = AW'(BASE_ADDR);
  localparam logic [AW-1:0] STEP_A  = AW'(STRIDE);
  localparam logic [DW-1:0] SEED_D  = DW'(DATA_SEED);
  localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;
  typedef enum logic [1:0] {M_SCRIPT, M_SEQ_RD, M_SEQ_WR, M_WR_THEN_RD} mode_t;

  state_t        state, state_nxt;
  mode_t         mode_q;
  logic [NW-1:0] num_q;
  logic [NW-1:0] idx;
  logic [NW-1:0] num_clamped;
  logic [NW-1:0] pair_idx;
  logic          latch_run;
  logic          issue;

  logic [AW-1:0]    tbl_addr [DEPTH];
  logic [DW-1:0]    tbl_data [DEPTH];
  logic [DEPTH-1:0] tbl_wr;

  logic          op_wr;
  logic [AW-1:0] op_addr;
  logic [DW-1:0] op_data;

  assign state_dbg   = state;
  assign num_clamped = (bus.num_ops > DEPTH_N) ? DEPTH_N : bus.num_ops;
  assign pair_idx    = idx >> 1;

  // Script table has no reset so a loaded script survives a reset-abort.
  always_ff @(posedge clk) begin
    if (!reset && bus.cfg_we && !bus.busy) begin
      tbl_addr[bus.cfg_idx] <= bus.cfg_addr;
      tbl_data[bus.cfg_idx] <= bus.cfg_data;
      tbl_wr[bus.cfg_idx]   <= bus.cfg_wr;
    end
  end

  // Operation descriptor for op number idx in the latched mode.
  always_comb begin
    op_wr   = 1'b0;
    op_addr = '0;
    op_data = '0;
    unique case (mode_q)
      M_SCRIPT: begin
        op_wr   = tbl_wr[idx[IW-1:0]];
        op_addr = tbl_addr[idx[IW-1:0]];
        op_data = tbl_data[idx[IW-1:0]];
      end
      M_SEQ_RD: begin
        op_wr   = 1'b0;
        op_addr = BASE_A + AW'(idx) * STEP_A;
      end
      M_SEQ_WR: begin
        op_wr   = 1'b1;
        op_addr = BASE_A + AW'(idx) * STEP_A;
        op_data = SEED_D + DW'(idx);
      end
      M_WR_THEN_RD: begin
        op_wr   = ~idx[0];
        op_addr = BASE_A + AW'(pair_idx) * STEP_A;
        op_data = SEED_D + DW'(pair_idx);
      end
      default: begin
        op_wr = 1'b0;
      end
    endcase
  end

  // Request bus: a strobe (mem_read or mem_write, never both) is high for exactly one cycle
  // per op and carries address/writedata in that same cycle; there is no acceptance signal --
  // stall=1 means the cache cannot take a request, and no strobe is launched while it is high.
  // address holds between strobes; writedata moves only on a write strobe.
  always_comb begin
    state_nxt = state;
    latch_run = 1'b0;
    issue     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          latch_run = 1'b1;
          state_nxt = (num_clamped == '0) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!bus.stall) begin
          issue     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.stall) begin
          state_nxt = (idx == num_q) ? S_FIN : S_ISSUE;
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decision so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      mode_q         <= M_SCRIPT;
      num_q          <= '0;
      idx            <= '0;
      bus.mem_read   <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.address    <= '0;
      bus.writedata  <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.ops_issued <= '0;
    end else begin
      state         <= state_nxt;
      bus.mem_read  <= issue & ~op_wr;
      bus.mem_write <= issue & op_wr;
      bus.busy      <= (state_nxt == S_ISSUE) || (state_nxt == S_WAIT);
      bus.done      <= (state_nxt == S_FIN);
      if (latch_run) begin
        mode_q         <= mode_t'(bus.mode);
        num_q          <= num_clamped;
        idx            <= '0;
        bus.ops_issued <= '0;
      end
      if (issue) begin
        bus.address    <= op_addr;
        idx            <= idx + NW'(1);
        bus.ops_issued <= bus.ops_issued + NW'(1);
        if (op_wr) begin
          bus.writedata <= op_data;
        end
      end
    end
  end

  strobe_exclusive_a: assert property (@(posedge clk) !(bus.mem_read && bus.mem_write));
endmodule
